mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide memory port between two word-level requesters: instruction fetch (f_*) and load/store data (d_*).
- Arbitrates between the two requesters.
- Serialises each access into 1/2/4 little-endian byte cycles.
- For loads, assembles and sign/zero-extends the read data; for stores, drives one write byte per cycle.
- Sits between the multicycle core control FSM and memory_maneger, replacing the core's inline pc/temp address mux and byte counters.

Parameters:
- AW, 32, address width; byte addressing; address arithmetic wraps modulo 2^AW.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; level; held with f_addr stable until f_ack.
- f_addr  in  AW  fetch byte address; fetch is always a word.
- f_ack  out  1  one-cycle pulse; f_rdata valid in this cycle.
- f_rdata  out  32  fetched word; holds value until next fetch completes.
- d_req  in  1  data request; level; all d_* inputs stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = half, 2 or 3 = word.
- d_unsigned  in  1  load zero-extend when 1, sign-extend when 0; ignored for stores.
- d_addr  in  AW  data byte address; misaligned addresses are legal.
- d_wdata  in  32  store data; lane k written to d_addr+k.
- d_ack  out  1  one-cycle completion pulse for loads and stores.
- d_rdata  out  32  extended load result; holds value until next load completes.
- mem_addr  out  AW  byte address to memory.
- mem_wdata  out  8  write byte.
- mem_we  out  1  write enable; memory commits on its own edge inside the cycle.
- mem_rdata  in  8  combinational read byte for the current mem_addr.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - f_ack = d_ack = 0, mem_we = 0, busy = 0.
  - mem_addr = 0, mem_wdata = 0, f_rdata = d_rdata = 0.
  - Round-robin pointer (when enabled) set so data wins the first contest.
- State machine: IDLE -> XFER -> RESP -> IDLE.
- IDLE:
  - If any request is pending, choose a winner.
  - Latch the winner's id, addr, nbytes (1/2/4), we, wdata and unsigned flag.
  - Clear byte counter cnt; go to XFER.
  - With no request, remain in IDLE.
  - mem_we = 0 throughout IDLE.
- Default arbitration: data has priority over fetch when both request in the same IDLE cycle.
- XFER:
  - mem_addr = base + cnt, wrapping modulo 2^AW.
  - Store: mem_we = 1 and mem_wdata = wdata lane cnt.
  - Load: mem_we = 0; mem_rdata is captured into lane cnt at posedge.
  - cnt increments each cycle; after lane nbytes-1, go to RESP.
- RESP:
  - Pulse the winner's ack; the matching rdata register is already updated.
  - Return to IDLE.
- Latency: request seen in IDLE cycle T gives ack in cycle T+nbytes+1. A word access takes 6 cycles from request to next IDLE.
- Load extension: result = {sign or zero fill, assembled bytes}. Word loads are unextended.
- mem_* outputs depend only on internal registers, never combinationally on f_*/d_* inputs.
- Requester handshake: the requester deasserts req at the posedge ending its ack cycle. A req still high in the following IDLE cycle is a new request.
- Requester dropping req mid-transfer: the transfer still completes and ack still pulses. The requester ignores it.
- Reset mid-transfer:
  - Abort immediately with no ack.
  - Bytes already written stay written.
  - rdata registers return to 0.
- d_size = 3 behaves exactly as a word access.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - A last-grant flag records the most recent winner.
  - On a simultaneous request, the other requester wins.
  - A lone requester always wins.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data over fetch.

Decomposition:
- Package mem_ctrl_pkg holds:
  - Size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - State encodings ST_IDLE, ST_XFER, ST_RESP.
  - Requester ids REQ_FETCH, REQ_DATA.
  - Function nbytes_of(size).
- One sub-module, mem_byte_lane, which is combinational:
  - Selects the write byte by lane.
  - Merges a read byte into a 32-bit accumulator.
  - Applies sign/zero extension by size.

Test Plan:
- Memory holds 0x78,0x56,0x34,0x12 at 0x10..0x13. Fetch 0x10 -> mem_addr 0x10,0x11,0x12,0x13 on consecutive cycles; f_ack at T+5; f_rdata = 0x12345678.
- Memory byte 0x80 at 0x40:
  - Signed byte load at 0x40 -> d_rdata 0xFFFFFF80.
  - Unsigned byte load at 0x40 -> d_rdata 0x00000080.
  - Signed half load at 0x41, with bytes 0x34 @0x41 and 0x92 @0x42 -> d_rdata 0xFFFF9234.
- Half store of 0x0000BEEF at 0x20 -> mem_we high exactly 2 cycles; 0xEF @0x20, 0xBE @0x21; 0x22 unchanged; d_ack at T+3.
- f_req and d_req rise in the same cycle:
  - Data served first, fetch acked after.
  - With ARB_ROUND_ROBIN_EN, a second simultaneous contest grants fetch first.
- Word store to 0x30 with rst raised after 2 byte cycles -> mem_we falls with rst (no posedge needed); no ack; only 0x30 and 0x31 modified; busy = 0.
- Word load at 0xFFFFFFFE -> mem_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001; little-endian assembly is correct.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: access sizes, FSM states,
// requester ids and the latched-grant record.
package mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

   // Everything about the winning request that must survive until its ack.
   typedef struct packed {
      logic        id;
      logic        we;
      logic        uns;
      logic [1:0]  size;
      logic [31:0] wdata;
   } grant_t;

   // Byte count of an access; size 3 is treated as a word.
   function automatic logic [2:0] nbytes_of(input logic [1:0] size);
      case (size)
         SZ_BYTE: nbytes_of = 3'd1;
         SZ_HALF: nbytes_of = 3'd2;
         default: nbytes_of = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and byte-wide memory port signals.
// slave: the arbiter side; master: requesters plus memory (testbench side).
interface mem_port_arbiter_if #(parameter int AW = 32);

   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_ack;
   logic [31:0]   f_rdata;

   logic          d_req;
   logic          d_we;
   logic [1:0]    d_size;
   logic          d_unsigned;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic          d_ack;
   logic [31:0]   d_rdata;

   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [7:0]    mem_rdata;

   logic          busy;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
      output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
      input  f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
   );

endinterface

// File: rtl/mem_port_arbiter_byte_lane.sv
// Combinational byte-lane helper: picks the store byte for a lane, merges a
// read byte into the load accumulator and sign/zero extends the merged value.
module mem_byte_lane
   import mem_ctrl_pkg::*;
(
   input  logic [31:0] wdata_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] acc_i,
   input  logic [7:0]  rbyte_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [7:0]  wbyte_o,
   output logic [31:0] merged_o,
   output logic [31:0] ext_o
);

   logic [4:0] bit_ofs;
   logic       fill;

   assign bit_ofs = {lane_i, 3'b000};

   // Lane select, read merge and extension of the merged result.
   always_comb begin
      wbyte_o                = wdata_i[bit_ofs +: 8];
      merged_o               = acc_i;
      merged_o[bit_ofs +: 8] = rbyte_i;
      fill                   = 1'b0;
      ext_o                  = merged_o;
      case (size_i)
         SZ_BYTE: begin
            fill  = ~unsigned_i & merged_o[7];
            ext_o = {{24{fill}}, merged_o[7:0]};
         end
         SZ_HALF: begin
            fill  = ~unsigned_i & merged_o[15];
            ext_o = {{16{fill}}, merged_o[15:0]};
         end
         default: ext_o = merged_o;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and load/store.
// Each access is split into 1/2/4 little-endian byte cycles.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests
// (default is fixed priority, data over fetch).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; pick a winner if anyone requests
// ST_XFER | one byte per cycle at base + cnt
// ST_RESP | pulse the winner's ack; rdata register already updated
module mem_port_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int AW = 32
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   logic [1:0]    state_q, state_d;
   grant_t        grant_q, grant_d;
   logic [AW-1:0] base_q, base_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   f_rdata_q, f_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;

   logic          win_data;
   logic          last_lane;
   logic [2:0]    nbytes;
   logic [7:0]    wbyte;
   logic [31:0]   merged;
   logic [31:0]   ext;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;

   // On a tie the requester that did not win last time goes first.
   always_comb win_data = bus.d_req && (!bus.f_req || (last_q == REQ_FETCH));

   // Remember the latest winner; reset so that data wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= REQ_FETCH;
      end else if (state_q == ST_IDLE && (bus.f_req || bus.d_req)) begin
         last_q <= win_data ? REQ_DATA : REQ_FETCH;
      end
   end
`else
   // Fixed priority: data beats fetch.
   always_comb win_data = bus.d_req;
`endif

   assign nbytes    = nbytes_of(grant_q.size);
   assign last_lane = ({1'b0, cnt_q} == (nbytes - 3'd1));

   mem_byte_lane u_lane (
      .wdata_i    (grant_q.wdata),
      .lane_i     (cnt_q),
      .acc_i      (acc_q),
      .rbyte_i    (bus.mem_rdata),
      .size_i     (grant_q.size),
      .unsigned_i (grant_q.uns),
      .wbyte_o    (wbyte),
      .merged_o   (merged),
      .ext_o      (ext)
   );

   // Next-state logic: grant, byte sequencing and load result update.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.f_req || bus.d_req) begin
               state_d = ST_XFER;
               cnt_d   = 2'd0;
               acc_d   = 32'd0;
               if (win_data) begin
                  grant_d.id    = REQ_DATA;
                  grant_d.we    = bus.d_we;
                  grant_d.uns   = bus.d_unsigned;
                  grant_d.size  = bus.d_size;
                  grant_d.wdata = bus.d_wdata;
                  base_d        = bus.d_addr;
               end else begin
                  grant_d.id    = REQ_FETCH;
                  grant_d.we    = 1'b0;
                  grant_d.uns   = 1'b1;
                  grant_d.size  = SZ_WORD;
                  grant_d.wdata = 32'd0;
                  base_d        = bus.f_addr;
               end
            end
         end
         ST_XFER: begin
            cnt_d = cnt_q + 2'd1;
            if (!grant_q.we) begin
               acc_d = merged;
            end
            if (last_lane) begin
               state_d = ST_RESP;
               if (!grant_q.we) begin
                  if (grant_q.id == REQ_DATA) begin
                     d_rdata_d = ext;
                  end else begin
                     f_rdata_d = ext;
                  end
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         base_q    <= '0;
         cnt_q     <= 2'd0;
         acc_q     <= 32'd0;
         f_rdata_q <= 32'd0;
         d_rdata_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign bus.mem_addr  = base_q + AW'(cnt_q);
   assign bus.mem_wdata = wbyte;
   assign bus.mem_we    = (state_q == ST_XFER) && grant_q.we;
   assign bus.f_ack     = (state_q == ST_RESP) && (grant_q.id == REQ_FETCH);
   assign bus.d_ack     = (state_q == ST_RESP) && (grant_q.id == REQ_DATA);
   assign bus.f_rdata   = f_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 256-byte aliased memory model.
module tb_mem_port_arbiter;
   import mem_ctrl_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32)) bus ();
   mem_port_arbiter #(.AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] mem [256];
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic        id;
      logic        chk_data;
      logic [31:0] data;
   } sb_t;
   sb_t sb[$];

   logic        rr_last;
   logic [31:0] trace [4];
   int          we_cycles;

   task automatic push(input logic id, input logic chkd, input logic [31:0] data);
      sb_t e;
      e.id = id; e.chk_data = chkd; e.data = data;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every ack must match the next expected entry.
   always @(negedge clk) begin
      sb_t e;
      if (!rst && (bus.f_ack || bus.d_ack)) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 32'(bus.f_ack) + 32'(bus.d_ack), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_id", {31'd0, bus.d_ack}, {31'd0, e.id});
            if (e.chk_data) begin
               if (e.id == REQ_DATA) chk("d_rdata", bus.d_rdata, e.data);
               else                  chk("f_rdata", bus.f_rdata, e.data);
            end
         end
      end
   end

   task automatic access(input logic is_data, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input string tag);
      int lat = -1;
      @(negedge clk);
      if (is_data) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size;
         bus.d_unsigned = uns; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.f_req = 1'b1; bus.f_addr = addr;
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k <= 4) trace[k-1] = bus.mem_addr;
         if (bus.mem_we) we_cycles++;
         if (is_data ? bus.d_ack : bus.f_ack) begin
            lat = k;
            break;
         end
      end
      if (is_data) bus.d_req = 1'b0;
      else         bus.f_req = 1'b0;
      rr_last = is_data ? REQ_DATA : REQ_FETCH;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic contest(input logic [1:0] dsize, input logic duns, input logic [31:0] daddr,
                          input logic [31:0] dexp, input logic [31:0] faddr,
                          input logic [31:0] fexp, input string tag);
      logic data_first;
      int   dn, d_lat, f_lat;
      data_first = RR_EN ? (rr_last == REQ_FETCH) : 1'b1;
      dn = (dsize == SZ_BYTE) ? 1 : (dsize == SZ_HALF) ? 2 : 4;
      if (data_first) begin
         push(REQ_DATA, 1'b1, dexp); push(REQ_FETCH, 1'b1, fexp);
         d_lat = dn + 1; f_lat = dn + 7;
      end else begin
         push(REQ_FETCH, 1'b1, fexp); push(REQ_DATA, 1'b1, dexp);
         f_lat = 5; d_lat = dn + 7;
      end
      fork
         access(1'b1, 1'b0, dsize, duns, daddr, 32'd0, d_lat, {tag, "_d"});
         access(1'b0, 1'b0, SZ_WORD, 1'b0, faddr, 32'd0, f_lat, {tag, "_f"});
      join
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0;
      bus.d_unsigned = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      rr_last = REQ_FETCH;
      we_cycles = 0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h78; mem[8'h11] <= 8'h56; mem[8'h12] <= 8'h34; mem[8'h13] <= 8'h12;
      mem[8'h40] <= 8'h80; mem[8'h41] <= 8'h34; mem[8'h42] <= 8'h92;
      mem[8'h22] <= 8'h5A;
      mem[8'hFE] <= 8'h11; mem[8'hFF] <= 8'h22; mem[8'h00] <= 8'h33; mem[8'h01] <= 8'h44;

      #12;
      chk("rst_f_ack", {31'd0, bus.f_ack}, 32'd0);
      chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      chk("rst_f_rdata", bus.f_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      push(REQ_FETCH, 1'b1, 32'h12345678);
      access(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 5, "fetch");
      for (int i = 0; i < 4; i++) chk("fetch_addr", trace[i], 32'h10 + 32'(i));

      push(REQ_DATA, 1'b1, 32'hFFFFFF80);
      access(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h40, 32'd0, 2, "lb");
      push(REQ_DATA, 1'b1, 32'h00000080);
      access(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h40, 32'd0, 2, "lbu");
      push(REQ_DATA, 1'b1, 32'hFFFF9234);
      access(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h41, 32'd0, 3, "lh");
      push(REQ_DATA, 1'b1, 32'h00009234);
      access(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h41, 32'd0, 3, "lhu");
      push(REQ_DATA, 1'b1, 32'h12345678);
      access(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 5, "lw_sz3");

      push(REQ_DATA, 1'b0, 32'd0);
      we_cycles = 0;
      access(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h20, 32'h0000BEEF, 3, "sh");
      chk("sh_we_cycles", 32'(we_cycles), 32'd2);
      @(negedge clk);
      chk("sh_mem20", {24'd0, mem[8'h20]}, 32'h000000EF);
      chk("sh_mem21", {24'd0, mem[8'h21]}, 32'h000000BE);
      chk("sh_mem22", {24'd0, mem[8'h22]}, 32'h0000005A);

      push(REQ_DATA, 1'b1, 32'h44332211);
      access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFE, 32'd0, 5, "lw_wrap");
      chk("wrap_addr0", trace[0], 32'hFFFFFFFE);
      chk("wrap_addr1", trace[1], 32'hFFFFFFFF);
      chk("wrap_addr2", trace[2], 32'h00000000);
      chk("wrap_addr3", trace[3], 32'h00000001);

      contest(SZ_BYTE, 1'b1, 32'h40, 32'h00000080, 32'h10, 32'h12345678, "tieA");
      push(REQ_DATA, 1'b1, 32'hFFFF9234);
      access(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h41, 32'd0, 3, "lh_mid");
      contest(SZ_BYTE, 1'b1, 32'h40, 32'h00000080, 32'h10, 32'h12345678, "tieB");

      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = SZ_WORD;
      bus.d_unsigned = 1'b0; bus.d_addr = 32'h30; bus.d_wdata = 32'hAABBCCDD;
      repeat (3) @(negedge clk);
      chk("rst_mid_we_before", {31'd0, bus.mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mid_d_ack", {31'd0, bus.d_ack}, 32'd0);
      chk("rst_mid_d_rdata", bus.d_rdata, 32'd0);
      chk("rst_mid_f_rdata", bus.f_rdata, 32'd0);
      bus.d_req = 1'b0;
      rr_last = REQ_FETCH;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mem30", {24'd0, mem[8'h30]}, 32'h000000DD);
      chk("rst_mem31", {24'd0, mem[8'h31]}, 32'h000000CC);
      chk("rst_mem32", {24'd0, mem[8'h32]}, 32'h00000000);
      chk("rst_mem33", {24'd0, mem[8'h33]}, 32'h00000000);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
